// File: rtl/axi_hp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_pkg
// Purpose  : Shared widths, response codes, FSM state types and address-range
//            helper for the HP0 stand-in responder.
// Revision : 1.0 - initial release
// ============================================================================
package axi_hp_pkg;

    localparam int AXI_ID_W   = 6;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_e;

    // True when the byte address falls inside the RAM window starting at base.
    function automatic logic addr_in_range(input logic [AXI_ADDR_W-1:0] addr,
                                           input logic [AXI_ADDR_W-1:0] base,
                                           input int                    depth_log2);
        logic [AXI_ADDR_W-1:0] offset;
        offset = addr - base;
        return (addr >= base) && ((offset >> (depth_log2 + 3)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_hp_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_responder_if
// Purpose  : AXI3 64-bit bus bundle between an HP-port master and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_hp_responder_if;
    import axi_hp_pkg::*;

    logic [AXI_ID_W-1:0]   s_axi_awid;
    logic [AXI_ADDR_W-1:0] s_axi_awaddr;
    logic [3:0]            s_axi_awlen;
    logic [2:0]            s_axi_awsize;
    logic [1:0]            s_axi_awburst;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [AXI_ID_W-1:0]   s_axi_wid;
    logic [AXI_DATA_W-1:0] s_axi_wdata;
    logic [AXI_STRB_W-1:0] s_axi_wstrb;
    logic                  s_axi_wlast;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [AXI_ID_W-1:0]   s_axi_bid;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [AXI_ID_W-1:0]   s_axi_arid;
    logic [AXI_ADDR_W-1:0] s_axi_araddr;
    logic [3:0]            s_axi_arlen;
    logic [2:0]            s_axi_arsize;
    logic [1:0]            s_axi_arburst;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [AXI_ID_W-1:0]   s_axi_rid;
    logic [AXI_DATA_W-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rlast;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );

endinterface
`default_nettype wire

// File: rtl/axi_hp_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_be
// Purpose  : Simple dual-port 64-bit RAM, byte-enabled write port, registered
//            read port that returns the old word on a same-address collision.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram_be
    import axi_hp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  wire logic                  clk_i,
    input  wire logic                  we_i,
    input  wire logic [DEPTH_LOG2-1:0] waddr_i,
    input  wire logic [AXI_DATA_W-1:0] wdata_i,
    input  wire logic [AXI_STRB_W-1:0] wstrb_i,
    input  wire logic                  re_i,
    input  wire logic [DEPTH_LOG2-1:0] raddr_i,
    output logic      [AXI_DATA_W-1:0] rdata_o
);

    logic [AXI_DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [AXI_DATA_W-1:0] rdata_q;
    logic [AXI_DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Non-blocking update of both the array and the read register gives read-first.
    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_hp_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_responder
// Purpose  : AXI3 64-bit slave standing in for the PS HP0 port, backed by
//            on-chip byte-enabled RAM; independent read and write FSMs.
// Revision : 1.0 - initial release
// ============================================================================
module axi_hp_responder
    import axi_hp_pkg::*;
#(
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input wire logic         clk_i,
    input wire logic         rst_i,
    axi_hp_responder_if.slave s_axi
);

    wr_state_e             wr_state_q, wr_state_d;
    logic [AXI_ID_W-1:0]   wr_id_q, wr_id_d;
    logic [AXI_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]            wr_len_q, wr_len_d;
    logic [3:0]            wr_beat_q, wr_beat_d;
    logic                  wr_err_q, wr_err_d;

    rd_state_e             rd_state_q, rd_state_d;
    logic [AXI_ID_W-1:0]   rd_id_q, rd_id_d;
    logic [AXI_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [3:0]            rd_len_q, rd_len_d;
    logic [3:0]            rd_beat_q, rd_beat_d;
    logic                  rd_rng_q, rd_rng_d;

    logic                  out_en_q, out_en_d;

    logic                  wr_in_range, wr_is_last, ram_we;
    logic                  rd_in_range, rd_is_last, rd_fetch;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
    logic [AXI_DATA_W-1:0] ram_rdata;
    logic                  unused_inputs;

    assign wr_in_range = addr_in_range(wr_addr_q, BASE_ADDR, DEPTH_LOG2);
    assign rd_in_range = addr_in_range(rd_addr_q, BASE_ADDR, DEPTH_LOG2);
    assign wr_idx      = DEPTH_LOG2'((wr_addr_q - BASE_ADDR) >> 3);
    assign rd_idx      = DEPTH_LOG2'((rd_addr_q - BASE_ADDR) >> 3);
    assign wr_is_last  = (wr_beat_q == wr_len_q);
    assign rd_is_last  = (rd_beat_q == rd_len_q);

    // Holds every ready/valid low for the whole reset and the edge that releases it.
    assign out_en_d = 1'b1;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        wr_beat_d  = wr_beat_q;
        wr_err_d   = wr_err_q;
        ram_we     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (out_en_q && s_axi.s_axi_awvalid) begin
                    wr_id_d    = s_axi.s_axi_awid;
                    wr_addr_d  = {s_axi.s_axi_awaddr[AXI_ADDR_W-1:3], 3'b000};
                    wr_len_d   = s_axi.s_axi_awlen;
                    wr_beat_d  = 4'd0;
                    wr_err_d   = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.s_axi_wvalid) begin
                    ram_we = wr_in_range;
                    if (!wr_in_range || (s_axi.s_axi_wlast != wr_is_last)) begin
                        wr_err_d = 1'b1;
                    end
                    wr_addr_d = wr_addr_q + 32'd8;
                    wr_beat_d = wr_beat_q + 4'd1;
                    // The beat count, not wlast, closes the burst.
                    if (wr_is_last) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        rd_rng_d   = rd_rng_q;
        rd_fetch   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (out_en_q && s_axi.s_axi_arvalid) begin
                    rd_id_d    = s_axi.s_axi_arid;
                    rd_addr_d  = {s_axi.s_axi_araddr[AXI_ADDR_W-1:3], 3'b000};
                    rd_len_d   = s_axi.s_axi_arlen;
                    rd_beat_d  = 4'd0;
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rd_fetch   = 1'b1;
                rd_rng_d   = rd_in_range;
                rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (s_axi.s_axi_rready) begin
                    if (rd_is_last) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_addr_d  = rd_addr_q + 32'd8;
                        rd_beat_d  = rd_beat_q + 4'd1;
                        rd_state_d = R_FETCH;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            wr_id_q    <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_err_q   <= 1'b0;
            rd_state_q <= R_IDLE;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_rng_q   <= 1'b0;
            out_en_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_id_q    <= wr_id_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_beat_q  <= wr_beat_d;
            wr_err_q   <= wr_err_d;
            rd_state_q <= rd_state_d;
            rd_id_q    <= rd_id_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_beat_q  <= rd_beat_d;
            rd_rng_q   <= rd_rng_d;
            out_en_q   <= out_en_d;
        end
    end

    sdp_ram_be #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wr_idx),
        .wdata_i (s_axi.s_axi_wdata),
        .wstrb_i (s_axi.s_axi_wstrb),
        .re_i    (rd_fetch),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    assign s_axi.s_axi_awready = out_en_q && (wr_state_q == W_IDLE);
    assign s_axi.s_axi_wready  = out_en_q && (wr_state_q == W_DATA);
    assign s_axi.s_axi_bvalid  = out_en_q && (wr_state_q == W_RESP);
    assign s_axi.s_axi_bid     = wr_id_q;
    assign s_axi.s_axi_bresp   = ((wr_state_q == W_RESP) && wr_err_q) ? RESP_SLVERR : RESP_OKAY;

    assign s_axi.s_axi_arready = out_en_q && (rd_state_q == R_IDLE);
    assign s_axi.s_axi_rvalid  = out_en_q && (rd_state_q == R_DATA);
    assign s_axi.s_axi_rid     = rd_id_q;
    assign s_axi.s_axi_rdata   = ((rd_state_q == R_DATA) && rd_rng_q) ? ram_rdata : '0;
    assign s_axi.s_axi_rresp   = ((rd_state_q == R_DATA) && !rd_rng_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.s_axi_rlast   = (rd_state_q == R_DATA) && rd_is_last;

    assign unused_inputs = ^{s_axi.s_axi_awsize, s_axi.s_axi_awburst, s_axi.s_axi_wid,
                             s_axi.s_axi_arsize, s_axi.s_axi_arburst,
                             s_axi.s_axi_awaddr[2:0], s_axi.s_axi_araddr[2:0]};

endmodule
`default_nettype wire
